// File: rtl/fas_analysis_if.sv
// FFT-frame input and peak-analysis result bundle for fas_analysis.
// peak_mag exists only when ANA_PEAK_OUT_EN is defined.
interface fas_analysis_if;
    logic        fft_valid;
    logic [31:0] fft_d0,  fft_d1,  fft_d2,  fft_d3;
    logic [31:0] fft_d4,  fft_d5,  fft_d6,  fft_d7;
    logic [31:0] fft_d8,  fft_d9,  fft_d10, fft_d11;
    logic [31:0] fft_d12, fft_d13, fft_d14, fft_d15;
    logic        done;
    logic [3:0]  freq;
    logic        busy;
    logic        overrun;
`ifdef ANA_PEAK_OUT_EN
    logic [31:0] peak_mag;

    modport master (
        output fft_valid,
        output fft_d0, fft_d1, fft_d2, fft_d3,
        output fft_d4, fft_d5, fft_d6, fft_d7,
        output fft_d8, fft_d9, fft_d10, fft_d11,
        output fft_d12, fft_d13, fft_d14, fft_d15,
        input  done, freq, busy, overrun, peak_mag
    );

    modport slave (
        input  fft_valid,
        input  fft_d0, fft_d1, fft_d2, fft_d3,
        input  fft_d4, fft_d5, fft_d6, fft_d7,
        input  fft_d8, fft_d9, fft_d10, fft_d11,
        input  fft_d12, fft_d13, fft_d14, fft_d15,
        output done, freq, busy, overrun, peak_mag
    );
`else
    modport master (
        output fft_valid,
        output fft_d0, fft_d1, fft_d2, fft_d3,
        output fft_d4, fft_d5, fft_d6, fft_d7,
        output fft_d8, fft_d9, fft_d10, fft_d11,
        output fft_d12, fft_d13, fft_d14, fft_d15,
        input  done, freq, busy, overrun
    );

    modport slave (
        input  fft_valid,
        input  fft_d0, fft_d1, fft_d2, fft_d3,
        input  fft_d4, fft_d5, fft_d6, fft_d7,
        input  fft_d8, fft_d9, fft_d10, fft_d11,
        input  fft_d12, fft_d13, fft_d14, fft_d15,
        output done, freq, busy, overrun
    );
`endif
endinterface

// File: rtl/fas_analysis.sv
// Ping-pong buffered FFT peak finder: scans one bin per cycle for max |X|^2.
// Optional ANA_PEAK_OUT_EN adds the peak_mag result register/port.
module fas_analysis (
    input  logic          clk,
    input  logic          rst,
    fas_analysis_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [31:0] din [16];
    logic [31:0] bank [2][16];

    logic [0:0]  state;
    logic [3:0]  idx;
    logic [1:0]  occ;
    logic        wsel;
    logic        rsel;
    logic [31:0] best_mag;
    logic [3:0]  best_idx;
    logic        done_q;
    logic [3:0]  freq_q;
    logic        ovr_q;

    assign din[0]  = bus.fft_d0;
    assign din[1]  = bus.fft_d1;
    assign din[2]  = bus.fft_d2;
    assign din[3]  = bus.fft_d3;
    assign din[4]  = bus.fft_d4;
    assign din[5]  = bus.fft_d5;
    assign din[6]  = bus.fft_d6;
    assign din[7]  = bus.fft_d7;
    assign din[8]  = bus.fft_d8;
    assign din[9]  = bus.fft_d9;
    assign din[10] = bus.fft_d10;
    assign din[11] = bus.fft_d11;
    assign din[12] = bus.fft_d12;
    assign din[13] = bus.fft_d13;
    assign din[14] = bus.fft_d14;
    assign din[15] = bus.fft_d15;

    logic accept;
    logic drop;
    logic scan;
    logic last;
    logic [1:0] occ_nxt;

    assign accept  = bus.fft_valid && (occ != 2'd2);
    assign drop    = bus.fft_valid && (occ == 2'd2);
    assign scan    = (state == SCAN);
    assign last    = scan && (idx == 4'd15);
    assign occ_nxt = occ + {1'b0, accept} - {1'b0, last};

    logic [31:0]        word;
    logic signed [31:0] re_x;
    logic signed [31:0] im_x;
    logic [31:0]        re_sq;
    logic [31:0]        im_sq;
    logic [31:0]        mag;
    logic               upd;
    logic [31:0]        nxt_mag;
    logic [3:0]         nxt_idx;

    // Each square is at most 2^30, so the unsigned sum never exceeds 2^31.
    assign word    = bank[rsel][idx];
    assign re_x    = {{16{word[31]}}, word[31:16]};
    assign im_x    = {{16{word[15]}}, word[15:0]};
    assign re_sq   = re_x * re_x;
    assign im_sq   = im_x * im_x;
    assign mag     = re_sq + im_sq;
    assign upd     = (idx == 4'd0) || (mag > best_mag);
    assign nxt_mag = upd ? mag : best_mag;
    assign nxt_idx = upd ? idx : best_idx;

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int k = 0; k < 16; k++) begin
                bank[wsel][k] <= din[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (scan) begin
            best_mag <= nxt_mag;
            best_idx <= nxt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 4'd0;
            occ    <= 2'd0;
            wsel   <= 1'b0;
            rsel   <= 1'b0;
            done_q <= 1'b0;
            freq_q <= 4'd0;
            ovr_q  <= 1'b0;
        end else begin
            done_q <= last;
            occ    <= occ_nxt;
            if (accept) wsel <= ~wsel;
            if (drop) ovr_q <= 1'b1;
            if (scan) idx <= idx + 4'd1;
            if (last) begin
                freq_q <= nxt_idx;
                rsel   <= ~rsel;
                if (occ_nxt == 2'd0) state <= IDLE;
            end else if (!scan && accept) begin
                state <= SCAN;
                idx   <= 4'd0;
            end
        end
    end

    assign bus.done    = done_q;
    assign bus.freq    = freq_q;
    assign bus.busy    = scan;
    assign bus.overrun = ovr_q;

`ifdef ANA_PEAK_OUT_EN
    logic [31:0] peak_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= 32'd0;
        end else if (last) begin
            peak_q <= nxt_mag;
        end
    end

    assign bus.peak_mag = peak_q;
`endif
endmodule

// File: tb/tb_fas_analysis.sv
// Directed bench for fas_analysis: frame vector table plus
// back-to-back, overrun and mid-scan reset sequences.
module tb_fas_analysis;
    typedef logic [15:0][31:0] frame_t;

    typedef struct packed {
        frame_t      d;
        logic [3:0]  freq;
        logic [31:0] mag;
    } vec_t;

    typedef struct {
        int          c;
        logic [3:0]  f;
        logic [31:0] m;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fas_analysis_if bus ();

    fas_analysis dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    ev_t evq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done) begin
            ev_t e;
            e.c = cyc;
            e.f = bus.freq;
`ifdef ANA_PEAK_OUT_EN
            e.m = bus.peak_mag;
`else
            e.m = 32'd0;
`endif
            evq.push_back(e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input frame_t d);
        bus.fft_valid = v;
        bus.fft_d0  = d[0];
        bus.fft_d1  = d[1];
        bus.fft_d2  = d[2];
        bus.fft_d3  = d[3];
        bus.fft_d4  = d[4];
        bus.fft_d5  = d[5];
        bus.fft_d6  = d[6];
        bus.fft_d7  = d[7];
        bus.fft_d8  = d[8];
        bus.fft_d9  = d[9];
        bus.fft_d10 = d[10];
        bus.fft_d11 = d[11];
        bus.fft_d12 = d[12];
        bus.fft_d13 = d[13];
        bus.fft_d14 = d[14];
        bus.fft_d15 = d[15];
    endtask

    // Data is scrambled after the capture edge to show it is ignored.
    task automatic send(input frame_t d, output int cap);
        drive(1'b1, d);
        @(posedge clk);
        #1;
        cap = cyc;
        drive(1'b0, ~d);
    endtask

    function automatic frame_t one(input int k, input logic [31:0] w);
        frame_t f;
        f = '0;
        f[k] = w;
        return f;
    endfunction

    vec_t   vecs [6];
    frame_t fa, fb, fc;
    int     c0, c1, c2;

    initial begin
        drive(1'b0, '0);

        vecs[0].d = '0;
        vecs[0].d[1]  = 32'h0100_0000;
        vecs[0].d[15] = 32'h0100_0000;
        vecs[0].freq  = 4'd1;
        vecs[0].mag   = 32'h0001_0000;

        vecs[1].d = '0;
        vecs[1].d[7] = 32'h8000_8000;
        vecs[1].d[3] = 32'h7FFF_7FFF;
        vecs[1].freq = 4'd7;
        vecs[1].mag  = 32'h8000_0000;

        vecs[2].d = '0;
        vecs[2].d[0] = 32'h0000_0003;
        vecs[2].d[5] = 32'hFFFD_0000;
        vecs[2].freq = 4'd0;
        vecs[2].mag  = 32'd9;

        vecs[3].d    = '0;
        vecs[3].freq = 4'd0;
        vecs[3].mag  = 32'd0;

        vecs[4].d = '0;
        vecs[4].d[4]  = 32'h0001_0001;
        vecs[4].d[10] = 32'h0003_0004;
        vecs[4].d[12] = 32'h0000_FFFB;
        vecs[4].freq  = 4'd10;
        vecs[4].mag   = 32'd25;

        vecs[5].d = '0;
        vecs[5].d[2]  = 32'h0001_0000;
        vecs[5].d[14] = 32'hFFFF_FFFF;
        vecs[5].freq  = 4'd14;
        vecs[5].mag   = 32'd2;

        rst = 1'b1;
        tick(3);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst freq", {28'd0, bus.freq}, 32'd0);
        chk("rst overrun", {31'd0, bus.overrun}, 32'd0);
`ifdef ANA_PEAK_OUT_EN
        chk("rst peak_mag", bus.peak_mag, 32'd0);
`endif
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 6; i++) begin
            evq.delete();
            send(vecs[i].d, c0);
            chk($sformatf("v%0d busy", i), {31'd0, bus.busy}, 32'd1);
            tick(24);
            chk($sformatf("v%0d pulses", i), evq.size(), 32'd1);
            if (evq.size() > 0) begin
                chk($sformatf("v%0d latency", i), evq[0].c - c0, 32'd16);
                chk($sformatf("v%0d freq", i), {28'd0, evq[0].f},
                    {28'd0, vecs[i].freq});
`ifdef ANA_PEAK_OUT_EN
                chk($sformatf("v%0d peak_mag", i), evq[0].m, vecs[i].mag);
`endif
            end
            chk($sformatf("v%0d freq hold", i), {28'd0, bus.freq},
                {28'd0, vecs[i].freq});
            chk($sformatf("v%0d idle", i), {31'd0, bus.busy}, 32'd0);
        end

        // Back-to-back frames every 16 cycles
        fa = one(2, 32'h0000_0010);
        fb = one(9, 32'h0005_0000);
        fb[1] = 32'h0001_0000;
        fc = one(15, 32'hFFF0_0000);
        fc[0] = 32'h000F_0000;
        evq.delete();
        send(fa, c0);
        tick(15);
        send(fb, c1);
        tick(15);
        send(fc, c2);
        tick(24);
        chk("b2b pulses", evq.size(), 32'd3);
        if (evq.size() == 3) begin
            chk("b2b t0", evq[0].c - c0, 32'd16);
            chk("b2b t1", evq[1].c - c1, 32'd16);
            chk("b2b t2", evq[2].c - c2, 32'd16);
            chk("b2b f0", {28'd0, evq[0].f}, 32'd2);
            chk("b2b f1", {28'd0, evq[1].f}, 32'd9);
            chk("b2b f2", {28'd0, evq[2].f}, 32'd15);
`ifdef ANA_PEAK_OUT_EN
            chk("b2b m1", evq[1].m, 32'd25);
            chk("b2b m2", evq[2].m, 32'd256);
`endif
        end
        chk("b2b overrun", {31'd0, bus.overrun}, 32'd0);

        // Three frames on consecutive edges: third is dropped
        fa = one(4, 32'h0002_0000);
        fb = one(6, 32'h0000_0003);
        fc = one(8, 32'h0007_0007);
        evq.delete();
        send(fa, c0);
        send(fb, c1);
        send(fc, c2);
        chk("ovr flag", {31'd0, bus.overrun}, 32'd1);
        tick(40);
        chk("ovr pulses", evq.size(), 32'd2);
        if (evq.size() == 2) begin
            chk("ovr t0", evq[0].c - c0, 32'd16);
            chk("ovr t1", evq[1].c - c0, 32'd32);
            chk("ovr f0", {28'd0, evq[0].f}, 32'd4);
            chk("ovr f1", {28'd0, evq[1].f}, 32'd6);
        end
        chk("ovr sticky", {31'd0, bus.overrun}, 32'd1);
        rst = 1'b1;
        tick(1);
        chk("ovr cleared", {31'd0, bus.overrun}, 32'd0);
        rst = 1'b0;
        tick(1);

        // Reset 8 cycles into a scan
        send(one(11, 32'h0009_0000), c0);
        tick(20);
        chk("pre-rst freq", {28'd0, bus.freq}, 32'd11);
        evq.delete();
        send(one(5, 32'h0000_0040), c0);
        tick(8);
        rst = 1'b1;
        tick(1);
        chk("midrst busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst freq", {28'd0, bus.freq}, 32'd0);
        rst = 1'b0;
        tick(30);
        chk("midrst no done", evq.size(), 32'd0);
        send(one(3, 32'h0010_0000), c0);
        tick(24);
        chk("post-rst pulses", evq.size(), 32'd1);
        if (evq.size() > 0) begin
            chk("post-rst latency", evq[0].c - c0, 32'd16);
            chk("post-rst freq", {28'd0, evq[0].f}, 32'd3);
        end

        // Data changing without fft_valid must not start a scan
        evq.delete();
        drive(1'b0, one(9, 32'h7FFF_0000));
        tick(20);
        chk("novalid pulses", evq.size(), 32'd0);
        chk("novalid busy", {31'd0, bus.busy}, 32'd0);
        chk("novalid freq", {28'd0, bus.freq}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
